// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the asynchronous FIFO read-side blocks.
// Holds the read-stream FSM state encoding and its width.
package fifo_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready stream carrying FIFO words plus a burst-end
// marker. The master drives data/last/valid, the slave drives ready.
interface fifo_rd_stream_if #(
  parameter int unsigned DSIZE = 8
) ();

  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_last,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry output buffer of {last, data} words. Entry 0 is the
// head shown on the stream; entry 1 holds the second word when the sink stalls.
// Occupancy is exported so the producer can stop pushing when full.
module fifo_rd_skid #(
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [DSIZE:0]   i_push_data,
  output logic [1:0]       o_occ,
  output logic [DSIZE-1:0] o_m_data,
  output logic             o_m_last,
  output logic             o_m_valid,
  input  logic             i_m_ready
);

  logic [DSIZE:0] r_buf0;
  logic [DSIZE:0] r_buf1;
  logic [1:0]     r_occ;
  logic           w_pop;

  assign w_pop = (r_occ != 2'd0) && i_m_ready;

  // Push/pop bookkeeping; entry 0 is always the oldest word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= i_push_data;
          else               r_buf1 <= i_push_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new word arrives: the new word lands behind
          // whatever remains, so occupancy is unchanged and order is kept.
          if (r_occ == 2'd1) begin
            r_buf0 <= i_push_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ     = r_occ;
  assign o_m_data  = r_buf0[DSIZE-1:0];
  assign o_m_last  = r_buf0[DSIZE];
  assign o_m_valid = (r_occ != 2'd0);

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer of the async FIFO. Pops words via
// rinc/rempty/rdata, tags every BLEN-th word as a burst end and presents them
// on a valid/ready stream through a 2-entry buffer. Draining only stops on a
// burst boundary.
// Optional feature macro: FIFO_RD_COUNT_EN (delivered-word counter on rd_count;
// when undefined rd_count is tied to zero).
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BLEN  = 4,
  parameter int unsigned CSIZE = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  en,
  fifo_rd_stream_if.master      m,
  output logic                  busy,
  output logic [CSIZE-1:0]      rd_count
);

  localparam int unsigned PW = $clog2(BLEN);
  localparam logic [PW-1:0] PLAST = PW'(BLEN - 1);

  rd_state_t        r_state;
  logic [PW-1:0]    r_pcnt;
  logic [PW-1:0]    w_pcnt_nxt;
  logic             w_wrap;
  logic [1:0]       w_occ;
  logic [DSIZE-1:0] w_m_data;
  logic             w_m_last;
  logic             w_m_valid;

  // Pop request: only from registered state/occupancy and the FIFO flag,
  // never from the stream ready.
  assign rinc   = ((r_state == ST_RUN) || (r_state == ST_FINISH)) &&
                  !rempty && (w_occ < 2'd2);
  assign w_wrap = rinc && (r_pcnt == PLAST);

  // Burst position after this cycle's pop, wrapping explicitly at BLEN-1.
  always_comb begin
    w_pcnt_nxt = r_pcnt;
    if (rinc) begin
      if (w_wrap) w_pcnt_nxt = '0;
      else        w_pcnt_nxt = r_pcnt + 1'b1;
    end
  end

  // Burst position register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) r_pcnt <= '0;
    else         r_pcnt <= w_pcnt_nxt;
  end

  // Drain control FSM.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // The burst position is judged after this cycle's pop (RUN keeps
          // popping while en is low), so a pop that starts a burst is
          // never left stranded in IDLE.
          if (!en) begin
            if (w_pcnt_nxt == '0) r_state <= ST_IDLE;
            else                  r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (w_wrap) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fifo_rd_skid #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk        (rclk),
    .rst_n      (rrst_n),
    .i_push     (rinc),
    .i_push_data({(r_pcnt == PLAST), rdata}),
    .o_occ      (w_occ),
    .o_m_data   (w_m_data),
    .o_m_last   (w_m_last),
    .o_m_valid  (w_m_valid),
    .i_m_ready  (m.m_ready)
  );

  assign m.m_data  = w_m_data;
  assign m.m_last  = w_m_last;
  assign m.m_valid = w_m_valid;

  assign busy = (r_state != ST_IDLE) || (w_occ != 2'd0);

`ifdef FIFO_RD_COUNT_EN
  logic [CSIZE-1:0] r_rd_count;

  // Delivered-word counter, wraps modulo 2^CSIZE.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                     r_rd_count <= '0;
    else if (w_m_valid && m.m_ready) r_rd_count <= r_rd_count + 1'b1;
  end

  assign rd_count = r_rd_count;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and randomized checks of fifo_rd_stream against
// a queue-based model of the FIFO contents and of the delivered stream.
// Built with BLEN=4 and CSIZE=4; counter expectations follow FIFO_RD_COUNT_EN.
module tb_fifo_rd_stream;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned BLEN  = 4;
  localparam int unsigned CSIZE = 4;

  logic             rclk   = 1'b0;
  logic             rrst_n = 1'b0;
  logic [DSIZE-1:0] rdata  = '0;
  logic             rempty = 1'b1;
  logic             en     = 1'b0;
  logic             rinc;
  logic             busy;
  logic [CSIZE-1:0] rd_count;

  fifo_rd_stream_if #(.DSIZE(DSIZE)) s_if ();

  fifo_rd_stream #(
    .DSIZE(DSIZE),
    .BLEN (BLEN),
    .CSIZE(CSIZE)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rdata   (rdata),
    .rempty  (rempty),
    .rinc    (rinc),
    .en      (en),
    .m       (s_if.master),
    .busy    (busy),
    .rd_count(rd_count)
  );

  always #5 rclk = ~rclk;

  // Reference state: FIFO contents, words owed to the stream, totals.
  logic [DSIZE-1:0] src_q[$];
  logic [DSIZE:0]   exp_q[$];
  logic [DSIZE-1:0] out_q[$];
  int unsigned      pop_cnt  = 0;
  int unsigned      xfer_cnt = 0;
  int unsigned      run_len  = 0;
  int unsigned      max_run  = 0;
  int unsigned      n_cmp    = 0;
  int unsigned      n_err    = 0;
  bit               hold_empty = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int unsigned n);
`ifdef FIFO_RD_COUNT_EN
    return 32'(n % (1 << CSIZE));
`else
    return 32'(n - n);
`endif
  endfunction

  // Advance one cycle; the FIFO flag and data are refreshed just after the edge.
  task automatic step();
    @(posedge rclk);
    #1;
    rempty = (src_q.size() == 0) || hold_empty;
    rdata  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // Cycle monitor: compares the stream against the model mid-cycle.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      exp_q.delete();
      pop_cnt  = 0;
      xfer_cnt = 0;
      run_len  = 0;
    end else begin
      chk("rinc_while_empty", 32'(rinc & rempty), 32'd0);
      chk("rinc_buffer_full", 32'(rinc && (exp_q.size() >= 2)), 32'd0);
      chk("m_valid", 32'(s_if.m_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("m_data", 32'(s_if.m_data), 32'(exp_q[0][DSIZE-1:0]));
        chk("m_last", 32'(s_if.m_last), 32'(exp_q[0][DSIZE]));
      end
      chk("rd_count", 32'(rd_count), cnt_exp(xfer_cnt));
      if (s_if.m_valid && s_if.m_ready && (exp_q.size() != 0)) begin
        out_q.push_back(exp_q[0][DSIZE-1:0]);
        void'(exp_q.pop_front());
        xfer_cnt++;
      end
      if (rinc) begin
        chk("pop_src_nonempty", 32'(src_q.size() != 0), 32'd1);
        if (src_q.size() != 0) begin
          exp_q.push_back({((pop_cnt % BLEN) == BLEN - 1), src_q.pop_front()});
        end
        pop_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    int unsigned base;
    int unsigned saved;

    s_if.m_ready = 1'b0;
    en           = 1'b1;
    rrst_n       = 1'b0;
    for (int unsigned i = 0; i < 8; i++) src_q.push_back(8'(8'h11 + i));
    repeat (3) step();

    // Reset values with en high and data waiting
    chk("rst_rempty_low", 32'(rempty), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_m_valid", 32'(s_if.m_valid), 32'd0);
    chk("rst_m_last", 32'(s_if.m_last), 32'd0);
    chk("rst_m_data", 32'(s_if.m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);

    // Streaming at full rate
    s_if.m_ready = 1'b1;
    rrst_n       = 1'b1;
    repeat (15) step();
    chk("stream_pops", pop_cnt, 32'd8);
    chk("stream_run", max_run, 32'd8);
    chk("stream_xfers", 32'(out_q.size()), 32'd8);
    for (int unsigned i = 0; i < 8; i++)
      chk("stream_data", (i < out_q.size()) ? 32'(out_q[i]) : 32'hDEAD, 32'(8'h11 + i));
    out_q.delete();

    // Backpressure: two pops then stall
    s_if.m_ready = 1'b0;
    base = pop_cnt;
    for (int unsigned i = 0; i < 8; i++) src_q.push_back(8'(8'h11 + i));
    repeat (10) step();
    chk("bp_pops", pop_cnt - base, 32'd2);
    chk("bp_rinc_low", 32'(rinc), 32'd0);
    chk("bp_valid", 32'(s_if.m_valid), 32'd1);
    chk("bp_head", 32'(s_if.m_data), 32'h11);
    s_if.m_ready = 1'b1;
    repeat (15) step();
    chk("bp_xfers", 32'(out_q.size()), 32'd8);
    for (int unsigned i = 0; i < 8; i++)
      chk("bp_data", (i < out_q.size()) ? 32'(out_q[i]) : 32'hDEAD, 32'(8'h11 + i));
    out_q.delete();

    // Burst boundary: en dropped after two pops
    base = pop_cnt;
    for (int unsigned i = 0; i < 8; i++) src_q.push_back(8'(8'h11 + i));
    for (int unsigned c = 0; c < 20; c++) begin
      step();
      if (pop_cnt - base >= 2) break;
    end
    chk("bb_pops_before_drop", pop_cnt - base, 32'd2);
    en = 1'b0;
    repeat (10) step();
    chk("bb_pops", pop_cnt - base, 32'd4);
    chk("bb_busy", 32'(busy), 32'd0);
    chk("bb_left", 32'(src_q.size()), 32'd4);
    chk("bb_head_left", (src_q.size() != 0) ? 32'(src_q[0]) : 32'hDEAD, 32'h15);
    chk("bb_xfers", 32'(out_q.size()), 32'd4);
    chk("bb_last_word", (out_q.size() == 4) ? 32'(out_q[3]) : 32'hDEAD, 32'h14);

    // Randomized traffic: empty flag, ready and enable all toggle
    en = 1'b1;
    for (int unsigned c = 0; c < 2500; c++) begin
      s_if.m_ready = ($urandom_range(0, 3) != 0);
      hold_empty   = ($urandom_range(0, 3) == 0);
      if (($urandom_range(0, 2) != 0) && (src_q.size() < 40)) src_q.push_back(8'($urandom));
      if ($urandom_range(0, 24) == 0) en = ~en;
      step();
    end

    // Drain: en off, enough data to close any open burst
    en           = 1'b0;
    hold_empty   = 1'b0;
    s_if.m_ready = 1'b1;
    repeat (BLEN) src_q.push_back(8'($urandom));
    for (int unsigned c = 0; c < 300; c++) begin
      step();
      if (!busy) break;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_whole_bursts", pop_cnt % BLEN, 32'd0);
    chk("drain_delivered", xfer_cnt, pop_cnt);
    saved = pop_cnt;
    repeat (5) step();
    chk("idle_no_pop", pop_cnt, saved);

    // Counter: reset, then 10 and 17 transfers
    src_q.delete();
    rrst_n = 1'b0;
    repeat (2) step();
    chk("rst2_rd_count", 32'(rd_count), 32'd0);
    rrst_n = 1'b1;
    en     = 1'b1;
    for (int unsigned i = 0; i < 10; i++) src_q.push_back(8'($urandom));
    for (int unsigned c = 0; c < 40; c++) begin
      step();
      if (xfer_cnt >= 10) break;
    end
    step();
    chk("cnt_xfers10", xfer_cnt, 32'd10);
    chk("cnt_10", 32'(rd_count), cnt_exp(10));
    for (int unsigned i = 0; i < 7; i++) src_q.push_back(8'($urandom));
    for (int unsigned c = 0; c < 40; c++) begin
      step();
      if (xfer_cnt >= 17) break;
    end
    step();
    chk("cnt_xfers17", xfer_cnt, 32'd17);
    chk("cnt_17_wrap", 32'(rd_count), cnt_exp(17));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
